// File: rtl/qspi_xip_fetch_pkg.sv
// Shared definitions for the XIP fetch engine and the QSPI master it drives:
// register offsets, STA/CCR bit positions and the fetch FSM state encoding.
package qspi_xip_fetch_pkg;

   localparam logic [5:0] REG_CCR     = 6'h00;
   localparam logic [5:0] REG_ADR     = 6'h04;
   localparam logic [5:0] REG_DR_BASE = 6'h08;
   localparam logic [5:0] REG_STA     = 6'h28;

   localparam int STA_DONE_BIT = 0;
   localparam int STA_BUSY_BIT = 1;

   localparam int CCR_CMD_LSB   = 0;
   localparam int CCR_MODE_LSB  = 8;
   localparam int CCR_ADDR_LSB  = 11;
   localparam int CCR_LEN_LSB   = 16;
   localparam int CCR_DIV_LSB   = 25;
   localparam int CCR_START_BIT = 31;

   localparam int LINE_WORDS = 8;
   localparam int TAG_W      = 19;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADR,
      ST_WR_CCR,
      ST_POLL,
      ST_RD_DR,
      ST_ERR
   } fetch_state_e;

   // Assembles a CCR word with the start bit set and all reserved bits zero.
   function automatic logic [31:0] build_ccr(input logic [7:0] cmd,
                                             input logic [1:0] mode,
                                             input logic [4:0] addr_field,
                                             input logic [4:0] len_field,
                                             input logic [5:0] clk_div);
      logic [31:0] ccr;
      ccr = '0;
      ccr[CCR_CMD_LSB  +: 8] = cmd;
      ccr[CCR_MODE_LSB +: 2] = mode;
      ccr[CCR_ADDR_LSB +: 5] = addr_field;
      ccr[CCR_LEN_LSB  +: 5] = len_field;
      ccr[CCR_DIV_LSB  +: 6] = clk_div;
      ccr[CCR_START_BIT]     = 1'b1;
      return ccr;
   endfunction

endpackage

// File: rtl/qspi_xip_fetch_if.sv
// Bundle of the CPU fetch port, the flush strobe and the QSPI master register
// port; the fetch engine is the slave side, its environment the master side.
interface qspi_xip_fetch_if;

   logic        fetch_req;
   logic [23:0] fetch_addr;
   logic        fetch_gnt;
   logic        fetch_rvalid;
   logic [31:0] fetch_rdata;
   logic        fetch_err;
   logic        flush;
   logic        qspi_write;
   logic [3:0]  qspi_be;
   logic [5:0]  qspi_addr;
   logic [31:0] qspi_wdata;
   logic [31:0] qspi_rdata;

   modport slave (
      input  fetch_req, fetch_addr, flush, qspi_rdata,
      output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      output qspi_write, qspi_be, qspi_addr, qspi_wdata
   );

   modport master (
      output fetch_req, fetch_addr, flush, qspi_rdata,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
      input  qspi_write, qspi_be, qspi_addr, qspi_wdata
   );

endinterface

// File: rtl/qspi_xip_linebuf.sv
// Single 32-byte line buffer: eight data words, a line tag and a valid bit,
// with a word write port and a combinational tag-compare read port.
module qspi_xip_linebuf
   import qspi_xip_fetch_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [2:0]       wr_idx_i,
   input  logic [31:0]      wr_data_i,
   input  logic             set_valid_i,
   input  logic [TAG_W-1:0] set_tag_i,
   input  logic             clr_valid_i,
   input  logic [TAG_W-1:0] lookup_tag_i,
   input  logic [2:0]       lookup_idx_i,
   output logic             hit_o,
   output logic [31:0]      rd_data_o
);

   logic [31:0]      word_q [LINE_WORDS];
   logic [31:0]      word_d [LINE_WORDS];
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             valid_q, valid_d;

   // Invalidation wins over a simultaneous fill completion.
   always_comb begin
      word_d  = word_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      if (wr_en_i) begin
         word_d[wr_idx_i] = wr_data_i;
      end
      if (clr_valid_i) begin
         valid_d = 1'b0;
      end else if (set_valid_i) begin
         valid_d = 1'b1;
         tag_d   = set_tag_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   always_ff @(posedge clk_i) begin
      word_q <= word_d;
   end

   assign hit_o     = valid_q && (tag_q == lookup_tag_i);
   assign rd_data_o = word_q[lookup_idx_i];

endmodule

// File: rtl/qspi_xip_fetch.sv
// Execute-in-place fetch engine: serves word fetches from a one-line buffer
// and refills it on a miss by running a complete QSPI master read transaction.
module qspi_xip_fetch
   import qspi_xip_fetch_pkg::*;
#(
   parameter logic [7:0]  CMD        = 8'h03,
   parameter logic [1:0]  MODE       = 2'b01,
   parameter logic [4:0]  ADDR_FIELD = 5'd23,
   parameter logic [4:0]  LEN_FIELD  = 5'd0,
   parameter logic [5:0]  CLK_DIV    = 6'd1,
   parameter int unsigned TIMEOUT    = 4096
) (
   input logic             clk_i,
   input logic             rst_i,
   qspi_xip_fetch_if.slave bus
);

   localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [31:0]      CCR_WORD = build_ccr(CMD, MODE, ADDR_FIELD, LEN_FIELD, CLK_DIV);

   fetch_state_e     state_q, state_d;
   logic [TAG_W-1:0] line_q, line_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       k_q, k_d;
   logic             flush_pend_q, flush_pend_d;
   logic             rvalid_q, rvalid_d;
   logic             err_q, err_d;
   logic [31:0]      rdata_q, rdata_d;

   logic        gnt;
   logic        qspi_write;
   logic [3:0]  qspi_be;
   logic [5:0]  qspi_addr;
   logic [31:0] qspi_wdata;

   logic        lb_hit;
   logic [31:0] lb_rdata;
   logic        lb_wr_en;
   logic        lb_set_valid;
   logic        lb_clr_valid;
   logic        unused_byte_sel;

   assign unused_byte_sel = ^bus.fetch_addr[1:0];

   qspi_xip_linebuf u_linebuf (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (lb_wr_en),
      .wr_idx_i     (k_q),
      .wr_data_i    (bus.qspi_rdata),
      .set_valid_i  (lb_set_valid),
      .set_tag_i    (line_q),
      .clr_valid_i  (lb_clr_valid),
      .lookup_tag_i (bus.fetch_addr[23:5]),
      .lookup_idx_i (bus.fetch_addr[4:2]),
      .hit_o        (lb_hit),
      .rd_data_o    (lb_rdata)
   );

   // A flush seen anywhere in a fill is remembered so the finished line stays invalid.
   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      cnt_d        = cnt_q;
      k_d          = k_q;
      flush_pend_d = flush_pend_q | (bus.flush && (state_q != ST_IDLE));
      rvalid_d     = 1'b0;
      err_d        = 1'b0;
      rdata_d      = '0;
      gnt          = 1'b0;
      qspi_write   = 1'b0;
      qspi_be      = '0;
      qspi_addr    = '0;
      qspi_wdata   = '0;
      lb_wr_en     = 1'b0;
      lb_set_valid = 1'b0;
      lb_clr_valid = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.flush) begin
               lb_clr_valid = 1'b1;
            end
            if (bus.fetch_req) begin
               if (lb_hit && !bus.flush) begin
                  gnt      = 1'b1;
                  rvalid_d = 1'b1;
                  rdata_d  = lb_rdata;
               end else begin
                  line_d       = bus.fetch_addr[23:5];
                  lb_clr_valid = 1'b1;
                  flush_pend_d = 1'b0;
                  state_d      = ST_WR_ADR;
               end
            end
         end
         ST_WR_ADR: begin
            qspi_write = 1'b1;
            qspi_addr  = REG_ADR;
            qspi_be    = 4'b0111;
            qspi_wdata = {8'h00, line_q, 5'b0};
            state_d    = ST_WR_CCR;
         end
         ST_WR_CCR: begin
            qspi_write = 1'b1;
            qspi_addr  = REG_CCR;
            qspi_be    = 4'hF;
            qspi_wdata = CCR_WORD;
            cnt_d      = '0;
            state_d    = ST_POLL;
         end
         ST_POLL: begin
            qspi_addr = REG_STA;
            qspi_be   = 4'b0001;
            if (bus.qspi_rdata[STA_DONE_BIT] && !bus.qspi_rdata[STA_BUSY_BIT]) begin
               k_d     = '0;
               state_d = ST_RD_DR;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RD_DR: begin
            qspi_addr = REG_DR_BASE + {1'b0, k_q, 2'b00};
            qspi_be   = 4'hF;
            lb_wr_en  = 1'b1;
            k_d       = k_q + 3'd1;
            if (k_q == 3'd7) begin
               lb_set_valid = !(flush_pend_q || bus.flush);
               flush_pend_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         ST_ERR: begin
            gnt          = bus.fetch_req;
            rvalid_d     = bus.fetch_req;
            err_d        = bus.fetch_req;
            flush_pend_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         line_q       <= '0;
         cnt_q        <= '0;
         k_q          <= '0;
         flush_pend_q <= 1'b0;
         rvalid_q     <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         line_q       <= line_d;
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         flush_pend_q <= flush_pend_d;
         rvalid_q     <= rvalid_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.fetch_gnt    = gnt;
   assign bus.fetch_rvalid = rvalid_q;
   assign bus.fetch_err    = err_q;
   assign bus.fetch_rdata  = rdata_q;
   assign bus.qspi_write   = qspi_write;
   assign bus.qspi_be      = qspi_be;
   assign bus.qspi_addr    = qspi_addr;
   assign bus.qspi_wdata   = qspi_wdata;

endmodule

// File: tb/tb_qspi_xip_fetch.sv
// Self-checking bench for qspi_xip_fetch: a behavioural QSPI master with a
// synthetic flash image, a line-level hit/miss reference model and fetch checks.
module tb_qspi_xip_fetch;

   localparam int          TMO       = 16;
   localparam logic [31:0] EXP_CCR   = 32'h8200_B903;
   localparam int          WAIT_LIMIT = 200;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   qspi_xip_fetch_if bus ();

   qspi_xip_fetch #(.TIMEOUT(TMO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [23:0] addr;
      int          delay;
      bit          flush_first;
      bit          exp_hit;
      int          exp_lat;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] m_adr;
   logic [31:0] m_dr [8];
   int          m_cnt;
   logic        m_armed;
   bit          m_hang = 1'b0;
   int          poll_delay = 1;

   int          n_activity;
   int          n_adr_writes;
   int          poll_seen;
   int          dr_next;
   int          dr_err;
   logic [31:0] last_adr;
   logic [3:0]  last_adr_be;
   logic [31:0] last_ccr;
   logic [5:0]  dr_off;

   function automatic logic [31:0] flash_word(input logic [23:0] a);
      logic [31:0] x;
      x = {8'h00, a[23:2], 2'b00};
      return (x * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ x;
   endfunction

   assign dr_off = bus.qspi_addr - 6'h08;

   // Register reads of the modelled QSPI master are combinational.
   always_comb begin
      bus.qspi_rdata = '0;
      if (!bus.qspi_write) begin
         if (bus.qspi_addr == 6'h28) begin
            bus.qspi_rdata = {30'b0, m_armed && (m_cnt != 0), m_armed && (m_cnt == 0)};
         end else if (bus.qspi_addr >= 6'h08 && bus.qspi_addr <= 6'h24) begin
            bus.qspi_rdata = m_dr[dr_off[4:2]];
         end
      end
   end

   // Master model: a started transfer stays busy for poll_delay cycles, then reports done.
   always @(posedge clk) begin
      if (rst) begin
         m_armed <= 1'b0;
         m_cnt   <= 0;
      end else begin
         if (bus.qspi_write || bus.qspi_be != 4'h0 || bus.qspi_addr != 6'h00)
            n_activity <= n_activity + 1;
         if (bus.qspi_write && bus.qspi_addr == 6'h04) begin
            m_adr        <= bus.qspi_wdata[23:0];
            last_adr     <= bus.qspi_wdata;
            last_adr_be  <= bus.qspi_be;
            n_adr_writes <= n_adr_writes + 1;
         end
         if (bus.qspi_write && bus.qspi_addr == 6'h00) begin
            last_ccr <= bus.qspi_wdata;
            if (bus.qspi_wdata[31]) begin
               m_armed   <= 1'b1;
               m_cnt     <= poll_delay;
               poll_seen <= 0;
               dr_next   <= 0;
               for (int j = 0; j < 8; j++) m_dr[j] <= flash_word(m_adr + 24'(4 * j));
            end
         end else if (m_cnt != 0 && !m_hang) begin
            m_cnt <= m_cnt - 1;
         end
         if (!bus.qspi_write && bus.qspi_addr == 6'h28)
            poll_seen <= poll_seen + 1;
         if (!bus.qspi_write && bus.qspi_be == 4'hF && bus.qspi_addr >= 6'h08 && bus.qspi_addr <= 6'h24) begin
            if (dr_off[4:2] != dr_next[2:0]) dr_err <= dr_err + 1;
            dr_next <= dr_next + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic pulseFlush();
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
   endtask

   // Issues one fetch (entered and left just after a rising edge) and checks latency and response.
   task automatic applyStimulus(input logic [23:0] a, input int delay, input bit exp_hit,
                                input bit exp_err, input int exp_lat, input string name);
      int cyc;
      bit got;
      int act0;
      poll_delay = delay;
      act0 = n_activity;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < WAIT_LIMIT) begin
         @(negedge clk);
         if (bus.fetch_gnt === 1'b1) got = 1'b1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      checkOutput({name, ".gnt_latency"}, 32'(cyc), 32'(exp_lat));
      @(posedge clk); #1;
      bus.fetch_req = 1'b0;
      @(negedge clk);
      checkOutput({name, ".rvalid"}, 32'(bus.fetch_rvalid), 32'd1);
      checkOutput({name, ".err"}, 32'(bus.fetch_err), 32'(exp_err));
      checkOutput({name, ".rdata"}, bus.fetch_rdata, exp_err ? 32'h0 : flash_word(a));
      if (exp_hit) begin
         checkOutput({name, ".qspi_idle"}, 32'(n_activity - act0), 32'd0);
      end else if (!exp_err) begin
         checkOutput({name, ".adr"}, last_adr, {8'h00, a[23:5], 5'b0});
         checkOutput({name, ".adr_be"}, 32'(last_adr_be), 32'h7);
         checkOutput({name, ".ccr"}, last_ccr, EXP_CCR);
         checkOutput({name, ".dr_order"}, 32'(dr_err), 32'd0);
         checkOutput({name, ".dr_count"}, 32'(dr_next), 32'd8);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({name, ".rvalid_pulse"}, 32'(bus.fetch_rvalid), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: run exceeded its time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs [8];
      bit          ref_valid;
      logic [18:0] ref_tag;
      bit          found;
      int          adr0;

      vecs[0] = '{24'h000104, 2, 1'b0, 1'b0, 14};
      vecs[1] = '{24'h000108, 1, 1'b0, 1'b1, 0};
      vecs[2] = '{24'h000120, 1, 1'b0, 1'b0, 13};
      vecs[3] = '{24'h000104, 3, 1'b0, 1'b0, 15};
      vecs[4] = '{24'h000100, 1, 1'b0, 1'b1, 0};
      vecs[5] = '{24'h000100, 1, 1'b1, 1'b0, 13};
      vecs[6] = '{24'h00FFFC, 4, 1'b0, 1'b0, 16};
      vecs[7] = '{24'h00FFE0, 1, 1'b0, 1'b1, 0};

      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.flush      = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset.gnt", 32'(bus.fetch_gnt), 32'd0);
      checkOutput("reset.rvalid", 32'(bus.fetch_rvalid), 32'd0);
      checkOutput("reset.err", 32'(bus.fetch_err), 32'd0);
      checkOutput("reset.rdata", bus.fetch_rdata, 32'd0);
      checkOutput("reset.qspi_write", 32'(bus.qspi_write), 32'd0);
      checkOutput("reset.qspi_be", 32'(bus.qspi_be), 32'd0);
      checkOutput("reset.qspi_addr", 32'(bus.qspi_addr), 32'd0);
      checkOutput("reset.qspi_wdata", bus.qspi_wdata, 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].flush_first) pulseFlush();
         applyStimulus(vecs[i].addr, vecs[i].delay, vecs[i].exp_hit, 1'b0, vecs[i].exp_lat,
                       $sformatf("vec%0d", i));
      end

      $display("[TB] back-to-back hits");
      applyStimulus(24'h000104, 2, 1'b0, 1'b0, 14, "b2b.fill");
      adr0 = n_activity;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 24'h000108;
      @(negedge clk);
      checkOutput("b2b.gnt0", 32'(bus.fetch_gnt), 32'd1);
      @(posedge clk); #1;
      bus.fetch_addr = 24'h00011C;
      @(negedge clk);
      checkOutput("b2b.gnt1", 32'(bus.fetch_gnt), 32'd1);
      checkOutput("b2b.rvalid0", 32'(bus.fetch_rvalid), 32'd1);
      checkOutput("b2b.rdata0", bus.fetch_rdata, flash_word(24'h000108));
      @(posedge clk); #1;
      bus.fetch_req = 1'b0;
      @(negedge clk);
      checkOutput("b2b.rvalid1", 32'(bus.fetch_rvalid), 32'd1);
      checkOutput("b2b.rdata1", bus.fetch_rdata, flash_word(24'h00011C));
      checkOutput("b2b.qspi_idle", 32'(n_activity - adr0), 32'd0);
      @(posedge clk); #1;

      $display("[TB] flush together with a hit");
      bus.flush = 1'b1;
      fork
         applyStimulus(24'h000110, 1, 1'b0, 1'b0, 13, "flushhit");
         begin
            @(posedge clk); #1;
            bus.flush = 1'b0;
         end
      join

      $display("[TB] poll timeout");
      m_hang = 1'b1;
      applyStimulus(24'h000300, 1, 1'b0, 1'b1, TMO + 3, "timeout");
      checkOutput("timeout.poll_cycles", 32'(poll_seen), 32'(TMO));
      m_hang = 1'b0;
      applyStimulus(24'h000300, 2, 1'b0, 1'b0, 14, "timeout.refetch");

      $display("[TB] flush during data drain");
      adr0  = n_adr_writes;
      found = 1'b0;
      fork
         applyStimulus(24'h000504, 2, 1'b0, 1'b0, 28, "flushfill");
         begin
            for (int c = 0; c < WAIT_LIMIT && !found; c++) begin
               @(negedge clk);
               if (!bus.qspi_write && bus.qspi_addr == 6'h14) found = 1'b1;
            end
            if (found) begin
               bus.flush = 1'b1;
               @(posedge clk); #1;
               bus.flush = 1'b0;
            end
         end
      join
      checkOutput("flushfill.k3_seen", 32'(found), 32'd1);
      checkOutput("flushfill.fills", 32'(n_adr_writes - adr0), 32'd2);

      $display("[TB] reset during poll");
      poll_delay     = 5;
      found          = 1'b0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 24'h000420;
      for (int c = 0; c < WAIT_LIMIT && !found; c++) begin
         @(negedge clk);
         if (!bus.qspi_write && bus.qspi_addr == 6'h28) found = 1'b1;
      end
      checkOutput("rstpoll.poll_seen", 32'(found), 32'd1);
      bus.fetch_req = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rstpoll.gnt", 32'(bus.fetch_gnt), 32'd0);
      checkOutput("rstpoll.rvalid", 32'(bus.fetch_rvalid), 32'd0);
      checkOutput("rstpoll.err", 32'(bus.fetch_err), 32'd0);
      checkOutput("rstpoll.rdata", bus.fetch_rdata, 32'd0);
      checkOutput("rstpoll.qspi_write", 32'(bus.qspi_write), 32'd0);
      checkOutput("rstpoll.qspi_be", 32'(bus.qspi_be), 32'd0);
      checkOutput("rstpoll.qspi_addr", 32'(bus.qspi_addr), 32'd0);
      checkOutput("rstpoll.qspi_wdata", bus.qspi_wdata, 32'd0);
      @(posedge clk); #1;
      applyStimulus(24'h000420, 1, 1'b0, 1'b0, 13, "rstpoll.refetch");

      $display("[TB] randomized fetches");
      pulseFlush();
      ref_valid = 1'b0;
      ref_tag   = '0;
      for (int i = 0; i < 40; i++) begin
         logic [23:0] a;
         int          d;
         bit          hit;
         if ($urandom_range(0, 9) == 0) begin
            pulseFlush();
            ref_valid = 1'b0;
         end
         a   = 24'h001000 + 24'($urandom_range(0, 95) << 2);
         d   = int'($urandom_range(1, 6));
         hit = ref_valid && (ref_tag == a[23:5]);
         applyStimulus(a, d, hit, 1'b0, hit ? 0 : 12 + d, $sformatf("rand%0d", i));
         ref_valid = 1'b1;
         ref_tag   = a[23:5];
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
